// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 memory responder.
// Holds the responder FSM states and the MMIO window layout.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [31:0] CONSOLE_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS  = 32'h4;
    localparam logic [31:0] CYCLE_OFS   = 32'h8;
    localparam logic [31:0] STATUS_PASS = 32'd1;

endpackage

// File: rtl/picorv32_mem_responder_if.sv
// picorv32 native memory bus bundle.
// The core is the master; the responder is the slave.
interface picorv32_mem_responder_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/picorv32_mem_ram.sv
// Single-port word RAM with per-byte write enables.
// Read is asynchronous, so a same-cycle write returns the old word.
module picorv32_mem_ram #(
    parameter int WORDS = 256,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    wen,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    reg [31:0] mem [0:WORDS-1];

    assign rdata = mem[idx];

    // Commit each enabled byte lane; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_responder.sv
// Simulation memory responder for the picorv32 native bus.
// RAM, programmable latency, console/status/cycle MMIO window.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] IO_BASE   = 32'h1000_0000,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    picorv32_mem_responder_if.slave    mem,
    output logic                       console_valid,
    output logic [7:0]                 console_data,
    output logic                       test_done,
    output logic                       test_pass,
    output logic                       bus_err
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] cyc_cnt;

    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        fire;
    logic        in_ram;
    logic        is_con;
    logic        is_stat;
    logic        is_cyc;
    logic        unmapped;
    logic        is_wr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rdata;
    logic [31:0] rd_data;
    logic        unused_instr;

    assign unused_instr = mem.mem_instr;

    // Pick the live request in IDLE (single-cycle case), else the captured one.
    always_comb begin
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_wstrb = cap_wstrb;
        if (state == S_IDLE) begin
            acc_addr  = mem.mem_addr;
            acc_wdata = mem.mem_wdata;
            acc_wstrb = mem.mem_wstrb;
        end
    end

    assign fire = resetn &&
                  (((state == S_IDLE) && mem.mem_valid && (LATENCY == 1)) ||
                   ((state == S_WAIT) && (wait_cnt == 8'd0)));

    assign in_ram   = {1'b0, acc_addr} < RAM_BYTES;
    assign is_con   = acc_addr == (IO_BASE + CONSOLE_OFS);
    assign is_stat  = acc_addr == (IO_BASE + STATUS_OFS);
    assign is_cyc   = acc_addr == (IO_BASE + CYCLE_OFS);
    assign unmapped = !(in_ram || is_con || is_stat || is_cyc);
    assign is_wr    = |acc_wstrb;
    assign ram_wen  = (fire && in_ram) ? acc_wstrb : 4'b0000;

    picorv32_mem_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .idx   (acc_addr[AW+1:2]),
        .wen   (ram_wen),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Read-data decode across RAM and the MMIO window.
    always_comb begin
        rd_data = ERR_RDATA;
        unique case (1'b1)
            in_ram:  rd_data = ram_rdata;
            is_con:  rd_data = 32'h0;
            is_stat: rd_data = {30'b0, test_pass, test_done};
            is_cyc:  rd_data = cyc_cnt;
            default: rd_data = ERR_RDATA;
        endcase
    end

    // Request FSM, latency counter, registered response and MMIO state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            wait_cnt      <= 8'd0;
            cap_addr      <= 32'h0;
            cap_wdata     <= 32'h0;
            cap_wstrb     <= 4'h0;
            cyc_cnt       <= 32'h0;
            mem.mem_ready <= 1'b0;
            mem.mem_rdata <= 32'h0;
            console_valid <= 1'b0;
            console_data  <= 8'h0;
            test_done     <= 1'b0;
            test_pass     <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            cyc_cnt       <= cyc_cnt + 32'd1;
            mem.mem_ready <= 1'b0;
            console_valid <= 1'b0;
            if (fire) begin
                mem.mem_ready <= 1'b1;
                mem.mem_rdata <= rd_data;
                if (is_wr && is_con) begin
                    console_valid <= 1'b1;
                    console_data  <= acc_wdata[7:0];
                end
                if (is_wr && is_stat && !test_done) begin
                    test_done <= 1'b1;
                    test_pass <= (acc_wdata == STATUS_PASS);
                end
                if (unmapped) begin
                    bus_err <= 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (mem.mem_valid) begin
                        cap_addr  <= mem.mem_addr;
                        cap_wdata <= mem.mem_wdata;
                        cap_wstrb <= mem.mem_wstrb;
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                        end else begin
                            wait_cnt <= 8'(LATENCY - 2);
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder.
// Four instances cover latencies 1, 4, 17 and 8.
module tb_picorv32_mem_responder;

    localparam logic [31:0] IOB = 32'h1000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rst8 = 1'b0;

    logic        b_valid = 1'b0;
    int          b_sel = 0;
    logic [31:0] b_addr = 32'h0;
    logic [31:0] b_wdata = 32'h0;
    logic [3:0]  b_wstrb = 4'h0;

    logic        rdy [4];
    logic [31:0] rdt [4];
    logic        cv [4];
    logic [7:0]  cd [4];
    logic        dn [4];
    logic        ps [4];
    logic        be [4];

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;
    int acc_cyc = 0;
    int con_n = 0;
    logic [7:0] con_last = 8'h0;
    int rdy8_n = 0;

    always #5 clk = ~clk;

    picorv32_mem_responder_if if0 ();
    picorv32_mem_responder_if if1 ();
    picorv32_mem_responder_if if2 ();
    picorv32_mem_responder_if if3 ();

    assign if0.mem_valid = b_valid && (b_sel == 0);
    assign if1.mem_valid = b_valid && (b_sel == 1);
    assign if2.mem_valid = b_valid && (b_sel == 2);
    assign if3.mem_valid = b_valid && (b_sel == 3);
    assign if0.mem_instr = 1'b0;
    assign if1.mem_instr = 1'b0;
    assign if2.mem_instr = 1'b0;
    assign if3.mem_instr = 1'b0;
    assign if0.mem_addr  = b_addr;
    assign if1.mem_addr  = b_addr;
    assign if2.mem_addr  = b_addr;
    assign if3.mem_addr  = b_addr;
    assign if0.mem_wdata = b_wdata;
    assign if1.mem_wdata = b_wdata;
    assign if2.mem_wdata = b_wdata;
    assign if3.mem_wdata = b_wdata;
    assign if0.mem_wstrb = b_wstrb;
    assign if1.mem_wstrb = b_wstrb;
    assign if2.mem_wstrb = b_wstrb;
    assign if3.mem_wstrb = b_wstrb;
    assign rdy[0] = if0.mem_ready;
    assign rdy[1] = if1.mem_ready;
    assign rdy[2] = if2.mem_ready;
    assign rdy[3] = if3.mem_ready;
    assign rdt[0] = if0.mem_rdata;
    assign rdt[1] = if1.mem_rdata;
    assign rdt[2] = if2.mem_rdata;
    assign rdt[3] = if3.mem_rdata;

    picorv32_mem_responder #(.LATENCY(1)) dut0 (
        .clk(clk), .resetn(rstn), .mem(if0.slave),
        .console_valid(cv[0]), .console_data(cd[0]),
        .test_done(dn[0]), .test_pass(ps[0]), .bus_err(be[0]));
    picorv32_mem_responder #(.LATENCY(4)) dut1 (
        .clk(clk), .resetn(rstn), .mem(if1.slave),
        .console_valid(cv[1]), .console_data(cd[1]),
        .test_done(dn[1]), .test_pass(ps[1]), .bus_err(be[1]));
    picorv32_mem_responder #(.LATENCY(17)) dut2 (
        .clk(clk), .resetn(rstn), .mem(if2.slave),
        .console_valid(cv[2]), .console_data(cd[2]),
        .test_done(dn[2]), .test_pass(ps[2]), .bus_err(be[2]));
    picorv32_mem_responder #(.LATENCY(8)) dut3 (
        .clk(clk), .resetn(rst8), .mem(if3.slave),
        .console_valid(cv[3]), .console_data(cd[3]),
        .test_done(dn[3]), .test_pass(ps[3]), .bus_err(be[3]));

    // Bench cycle count and pulse counters, sampled mid-cycle.
    always @(posedge clk) tb_cyc <= tb_cyc + 1;
    always @(negedge clk) begin
        if (cv[0]) begin
            con_n    <= con_n + 1;
            con_last <= cd[0];
        end
        if (rdy[3]) rdy8_n <= rdy8_n + 1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic req(input int k, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input int lat, input bit tog,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        b_sel = k; b_addr = a; b_wdata = wd; b_wstrb = ws; b_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = tb_cyc;
        n = 0;
        while (!rdy[k] && n < 300) begin
            if (tog) b_addr = b_addr ^ 32'h4;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat - 1));
        rd = rdt[k];
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        check("ready_pulse_len", {31'b0, rdy[k]}, 32'h0);
    endtask

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          lat;
        bit          tog;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] rd;
        logic [31:0] c1;
        logic [31:0] c2;
        int t1;
        int pre;

        vt[0]  = '{0, 32'h3FC, 32'h1234_5678, 4'hF, 1, 0, 0, 32'h0};
        vt[1]  = '{0, 32'h3FC, 32'h0, 4'h0, 1, 0, 1, 32'h1234_5678};
        vt[2]  = '{0, 32'h10, 32'hAABB_CCDD, 4'hF, 1, 0, 0, 32'h0};
        vt[3]  = '{0, 32'h10, 32'h1122_3344, 4'h5, 1, 0, 1, 32'hAABB_CCDD};
        vt[4]  = '{0, 32'h10, 32'h0, 4'h0, 1, 0, 1, 32'hAA22_CC44};
        vt[5]  = '{0, 32'h13, 32'h0, 4'h0, 1, 0, 1, 32'hAA22_CC44};
        vt[6]  = '{0, IOB + 4, 32'h0, 4'h0, 1, 0, 1, 32'h0};
        vt[7]  = '{1, 32'h40, 32'h600D_F00D, 4'hF, 4, 0, 0, 32'h0};
        vt[8]  = '{1, 32'h44, 32'h1212_1212, 4'hF, 4, 0, 0, 32'h0};
        vt[9]  = '{1, 32'h40, 32'h0, 4'h0, 4, 1, 1, 32'h600D_F00D};
        vt[10] = '{2, 32'h40, 32'h0BAD_CAFE, 4'hF, 17, 1, 0, 32'h0};
        vt[11] = '{2, 32'h40, 32'h0, 4'h0, 17, 0, 1, 32'h0BAD_CAFE};
        vt[12] = '{2, 32'h44, 32'h7777_7777, 4'hF, 17, 0, 0, 32'h0};
        vt[13] = '{2, 32'h40, 32'h0, 4'h0, 17, 1, 1, 32'h0BAD_CAFE};
        vt[14] = '{3, 32'h20, 32'hCAFE_F00D, 4'hF, 8, 0, 0, 32'h0};
        vt[15] = '{3, 32'h20, 32'h0, 4'h0, 8, 0, 1, 32'hCAFE_F00D};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, rdy[0]}, 32'h0);
        check("rst_rdata", rdt[0], 32'h0);
        check("rst_console", {31'b0, cv[0]}, 32'h0);
        check("rst_cdata", {24'b0, cd[0]}, 32'h0);
        check("rst_done", {31'b0, dn[0]}, 32'h0);
        check("rst_pass", {31'b0, ps[0]}, 32'h0);
        check("rst_buserr", {31'b0, be[0]}, 32'h0);
        check("rst8_ready", {31'b0, rdy[3]}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        rst8 = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req(vt[i].k, vt[i].a, vt[i].wd, vt[i].ws, vt[i].lat,
                vt[i].tog, rd);
            if (vt[i].chk) check($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        pre = con_n;
        req(0, IOB, 32'hFFFF_FF41, 4'h1, 1, 0, rd);
        @(negedge clk);
        check("con_pulses", 32'(con_n - pre), 32'd1);
        check("con_data", {24'b0, con_last}, 32'h41);
        req(0, IOB, 32'h0, 4'h0, 1, 0, rd);
        check("con_read", rd, 32'h0);
        check("con_no_pulse_read", 32'(con_n - pre), 32'd1);

        check("done_pre", {31'b0, dn[0]}, 32'h0);
        req(0, IOB + 4, 32'h1, 4'hF, 1, 0, rd);
        #1;
        check("done_set", {31'b0, dn[0]}, 32'h1);
        check("pass_set", {31'b0, ps[0]}, 32'h1);
        req(0, IOB + 4, 32'h0, 4'hF, 1, 0, rd);
        check("done_sticky", {31'b0, dn[0]}, 32'h1);
        check("pass_sticky", {31'b0, ps[0]}, 32'h1);
        req(0, IOB + 4, 32'h0, 4'h0, 1, 0, rd);
        check("status_read", rd, 32'h3);

        req(0, IOB + 8, 32'h0, 4'h0, 1, 0, rd);
        c1 = rd;
        t1 = acc_cyc;
        repeat (9) @(negedge clk);
        req(0, IOB + 8, 32'h0, 4'h0, 1, 0, rd);
        c2 = rd;
        check("cyc_delta", c2 - c1, 32'(acc_cyc - t1));

        check("buserr_pre", {31'b0, be[0]}, 32'h0);
        req(0, 32'h2000_0000, 32'h0, 4'h0, 1, 0, rd);
        check("unmapped_rdata", rd, 32'hDEAD_BEEF);
        check("buserr_set", {31'b0, be[0]}, 32'h1);
        req(0, 32'h2000_0010, 32'h0, 4'hF, 1, 0, rd);
        req(0, 32'h10, 32'h0, 4'h0, 1, 0, rd);
        check("unmapped_no_write", rd, 32'hAA22_CC44);
        req(0, 32'h400, 32'h0, 4'h0, 1, 0, rd);
        check("ram_end_unmapped", rd, 32'hDEAD_BEEF);
        check("buserr_sticky", {31'b0, be[0]}, 32'h1);

        pre = rdy8_n;
        @(negedge clk);
        b_sel = 3; b_addr = 32'h20; b_wdata = 32'h0BAD_0BAD;
        b_wstrb = 4'hF; b_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_mid_no_ready", 32'(rdy8_n - pre), 32'd0);
        req(3, 32'h20, 32'h0, 4'h0, 8, 0, rd);
        check("rst_mid_no_write", rd, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
